// File: rtl/canny_pkg.sv
// Shared definitions for the Canny edge pipeline stages.
package canny_pkg;

  typedef enum logic [1:0] {FILL, CALC, WRITE, ADVANCE} state_t;

  // Separable binomial kernel; the outer product sums to 256.
  localparam logic [4:0][3:0] KERNEL = {4'd1, 4'd4, 4'd6, 4'd4, 4'd1};
  localparam int ROUND = 128;
  localparam int SHIFT = 8;

endpackage

// File: rtl/gaussian_blur_if.sv
// FIFO-side handshake of the Gaussian blur stage: input FIFO pop and output FIFO push.
interface gaussian_blur_if;
  logic       in_rd_en;
  logic       in_empty;
  logic [7:0] in_dout;
  logic       out_wr_en;
  logic       out_full;
  logic [7:0] out_din;

  modport master (output in_rd_en, out_wr_en, out_din,
                  input  in_empty, in_dout, out_full);
  modport slave  (input  in_rd_en, out_wr_en, out_din,
                  output in_empty, in_dout, out_full);
endinterface

// File: rtl/gaussian_blur_kernel_5x5.sv
// Combinational 5x5 Gaussian weighted sum with round-to-nearest down to 8 bits.
module gaussian_kernel_5x5
  import canny_pkg::*;
(
  input  logic [24:0][7:0] i_taps,
  output logic [7:0]       o_result
);

  // Max sum is 65280, so adding ROUND cannot overflow 16 bits.
  function automatic logic [7:0] round_shift(input logic [15:0] sum);
    logic [15:0] t;
    t = sum + 16'(ROUND);
    return t[SHIFT +: 8];
  endfunction

  logic [15:0] w_sum;

  always_comb begin
    w_sum = '0;
    for (int dy = 0; dy < 5; dy++) begin
      for (int dx = 0; dx < 5; dx++) begin
        w_sum = w_sum + 16'(KERNEL[dy]) * 16'(KERNEL[dx]) * 16'(i_taps[dy*5+dx]);
      end
    end
  end

  assign o_result = round_shift(w_sum);

endmodule

// File: rtl/gaussian_blur.sv
// 5x5 Gaussian smoothing stage: raster-order FIFO in, raster-order FIFO out,
// one output per three cycles; border pixels pass through unchanged.
module gaussian_blur
  import canny_pkg::*;
#(
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 540
) (
  input  logic            clock,
  input  logic            reset,
  gaussian_blur_if.master bus
);

  localparam int SR_LEN = 4*WIDTH + 5;
  localparam int CENTRE = 2*WIDTH + 2;
  localparam int NPIX   = WIDTH*HEIGHT;
  localparam int CW     = $clog2(NPIX + 1);
  localparam int RW     = $clog2(HEIGHT);
  localparam int XW     = $clog2(WIDTH);

  localparam logic [CW-1:0] FILL_LAST = CW'(2*WIDTH + 2);
  localparam logic [CW-1:0] CNT_END   = CW'(NPIX);
  localparam logic [RW-1:0] ROW_LO    = RW'(2);
  localparam logic [RW-1:0] ROW_HI    = RW'(HEIGHT - 3);
  localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);
  localparam logic [XW-1:0] COL_LO    = XW'(2);
  localparam logic [XW-1:0] COL_HI    = XW'(WIDTH - 3);
  localparam logic [XW-1:0] COL_LAST  = XW'(WIDTH - 1);

  state_t          r_state, w_next;
  logic [CW-1:0]   r_in_cnt;
  logic [RW-1:0]   r_out_row;
  logic [XW-1:0]   r_out_col;
  logic [7:0]      r_result;
  logic [7:0]      r_sr [SR_LEN];

  logic            w_rd, w_wr, w_shift, w_last_px, w_border;
  logic [7:0]      w_shift_data, w_gauss;
  logic [24:0][7:0] w_taps;

  for (genvar dy = 0; dy < 5; dy++) begin : g_row
    for (genvar dx = 0; dx < 5; dx++) begin : g_col
      assign w_taps[dy*5+dx] = r_sr[dy*WIDTH+dx];
    end
  end

  gaussian_kernel_5x5 u_kernel (
    .i_taps   (w_taps),
    .o_result (w_gauss)
  );

  assign w_last_px = (r_out_row == ROW_LAST) && (r_out_col == COL_LAST);
  assign w_border  = (r_out_row < ROW_LO) || (r_out_row > ROW_HI) ||
                     (r_out_col < COL_LO) || (r_out_col > COL_HI);

  always_comb begin
    w_next       = r_state;
    w_rd         = 1'b0;
    w_wr         = 1'b0;
    w_shift      = 1'b0;
    w_shift_data = bus.in_dout;
    case (r_state)
      FILL: begin
        if (!bus.in_empty) begin
          w_rd    = 1'b1;
          w_shift = 1'b1;
          if (r_in_cnt == FILL_LAST) w_next = CALC;
        end
      end
      CALC: w_next = WRITE;
      WRITE: begin
        if (!bus.out_full) begin
          w_wr   = 1'b1;
          w_next = w_last_px ? FILL : ADVANCE;
        end
      end
      ADVANCE: begin
        if (r_in_cnt < CNT_END) begin
          if (!bus.in_empty) begin
            w_rd    = 1'b1;
            w_shift = 1'b1;
            w_next  = CALC;
          end
        end else begin
          // Epilogue: the remaining windows are all border windows.
          w_shift      = 1'b1;
          w_shift_data = 8'h00;
          w_next       = CALC;
        end
      end
      default: w_next = FILL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= FILL;
      r_in_cnt  <= '0;
      r_out_row <= '0;
      r_out_col <= '0;
      r_result  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == CALC) r_result <= w_border ? r_sr[CENTRE] : w_gauss;
      if (w_rd) r_in_cnt <= r_in_cnt + 1'b1;
      if (w_wr) begin
        if (w_last_px) begin
          r_in_cnt  <= '0;
          r_out_row <= '0;
          r_out_col <= '0;
        end else if (r_out_col == COL_LAST) begin
          r_out_col <= '0;
          r_out_row <= r_out_row + 1'b1;
        end else begin
          r_out_col <= r_out_col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SR_LEN; i++) r_sr[i] <= 8'h00;
    end else if (w_shift) begin
      for (int i = 0; i < SR_LEN-1; i++) r_sr[i] <= r_sr[i+1];
      r_sr[SR_LEN-1] <= w_shift_data;
    end
  end

  assign bus.in_rd_en  = w_rd;
  assign bus.out_wr_en = w_wr;
  assign bus.out_din   = r_result;

endmodule
